// File: rtl/channel_rx_fifo_pkg.sv
// Shared router definitions: flit field sizes, channel depth and the
// saturating counter helper used by the optional drop counter.
package channel_rx_fifo_pkg;

  localparam int HDR_SZ   = 4;
  localparam int PL_SZ    = 8;
  localparam int ADDR_SZ  = 4;
  localparam int CH_DEPTH = 4;

  localparam int FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int DROP_W = 8;

  typedef logic [FLIT_W-1:0] flit_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/channel_rx_fifo_ptr_ctrl.sv
// Pointer/occupancy control for the channel receive FIFO.
// Handshake: a write is accepted when ena_in & (!busy | pop); a pop happens
// when read & valid. valid/busy come from the registered count only, so they
// never depend combinationally on ena_in or read.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena_in,
  input  logic          read,
  output logic [AW-1:0] wp,
  output logic [AW-1:0] rp,
  output logic [AW:0]   count,
  output logic          valid,
  output logic          busy,
  output logic          write_en,
  output logic          pop
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Status flags and accept/pop decisions from registered occupancy.
  always_comb begin
    valid    = (count != '0);
    busy     = (count == FULL_CNT);
    pop      = read & valid;
    write_en = ena_in & (~busy | pop);
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (write_en) wp <= wp + AW'(1);
      if (pop)      rp <= rp + AW'(1);
      case ({write_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/channel_rx_fifo.sv
// Input channel buffer for one router link. Holds the flit array and head
// read mux; pointer/count control lives in fifo_ptr_ctrl.
// Optional feature macro: CHANNEL_DROP_CNT_EN adds an 8-bit saturating
// drop_cnt output counting flits offered while full without a pop.
module channel_rx_fifo
  import channel_rx_fifo_pkg::*;
#(
  parameter int DEPTH = CH_DEPTH,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  flit_t       item_in,
  input  logic        ena_in,
  output logic        busy,
  output flit_t       item_out,
  output logic        valid,
  input  logic        read,
  output logic [AW:0] count
`ifdef CHANNEL_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          write_en;
  logic          pop;
  flit_t         mem [DEPTH];

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ptr_ctrl (
    .clk      (clk),
    .reset    (reset),
    .ena_in   (ena_in),
    .read     (read),
    .wp       (wp),
    .rp       (rp),
    .count    (count),
    .valid    (valid),
    .busy     (busy),
    .write_en (write_en),
    .pop      (pop)
  );

  // Flit storage; contents survive reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (write_en) mem[wp] <= item_in;
  end

  // Head flit, forced to zero when empty so stale data never shows.
  always_comb begin
    item_out = valid ? mem[rp] : '0;
  end

`ifdef CHANNEL_DROP_CNT_EN
  logic drop;
  assign drop = ena_in & busy & ~read;

  // Saturating count of flits dropped at full; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_channel_rx_fifo.sv
// Bench for channel_rx_fifo: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_channel_rx_fifo;
  import channel_rx_fifo_pkg::*;

  localparam int DEPTH = CH_DEPTH;
  localparam int AW    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flit_t       item_in;
  flit_t       item_out;
  logic        ena_in;
  logic        read;
  logic        busy;
  logic        valid;
  logic [AW:0] count;
`ifdef CHANNEL_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  channel_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .item_in  (item_in),
    .ena_in   (ena_in),
    .busy     (busy),
    .item_out (item_out),
    .valid    (valid),
    .read     (read),
    .count    (count)
`ifdef CHANNEL_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // scoreboard state
  logic [FLIT_W-1:0] exp_q[$];
  int    exp_drops = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  int    m_sz;
  bit    m_pop;
  bit    m_wr;
  flit_t exp_item;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of flits obeying the accept/pop rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_drops = 0;
    end else begin
      m_sz  = exp_q.size();
      m_pop = read && (m_sz > 0);
      m_wr  = ena_in && ((m_sz < DEPTH) || m_pop);
      if (ena_in && (m_sz == DEPTH) && !read && exp_drops < 255) exp_drops++;
      if (m_pop) void'(exp_q.pop_front());
      if (m_wr) exp_q.push_back(item_in);
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_item = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("valid", 32'(valid), 32'(exp_q.size() > 0));
      chk("busy", 32'(busy), 32'(exp_q.size() == DEPTH));
      chk("item_out", 32'(item_out), 32'(exp_item));
`ifdef CHANNEL_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif
    end
  end

  // driver: apply one cycle of inputs, return 1 time unit after the edge
  task automatic cyc(input bit e, input flit_t d, input bit r);
    ena_in  = e;
    item_in = d;
    read    = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    ena_in  = 1'b0;
    read    = 1'b0;
    item_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // fill 0x11..0x14
    for (int i = 0; i < 4; i++) cyc(1'b1, flit_t'(16'h11 + i), 1'b0);
    chk("fill_count", 32'(count), 4);
    chk("fill_busy", 32'(busy), 1);
    chk("fill_head", 32'(item_out), 32'h11);

    // full with simultaneous write and pop
    cyc(1'b1, flit_t'(16'h55), 1'b1);
    chk("fullwr_count", 32'(count), 4);
    chk("fullwr_head", 32'(item_out), 32'h12);

    // overflow drop
    cyc(1'b1, flit_t'(16'hAA), 1'b0);
    chk("drop_count", 32'(count), 4);
    chk("drop_head", 32'(item_out), 32'h12);
`ifdef CHANNEL_DROP_CNT_EN
    chk("drop_cnt1", 32'(drop_cnt), 1);
`endif

    // drain in order
    begin
      logic [15:0] order [4];
      order[0] = 16'h12; order[1] = 16'h13; order[2] = 16'h14; order[3] = 16'h55;
      for (int i = 0; i < 4; i++) begin
        chk("drain_head", 32'(item_out), 32'(order[i]));
        cyc(1'b0, '0, 1'b1);
      end
    end
    chk("drained_valid", 32'(valid), 0);
    chk("drained_count", 32'(count), 0);

    // empty edge cases
    cyc(1'b0, '0, 1'b1);
    chk("empty_rd_count", 32'(count), 0);
    cyc(1'b1, flit_t'(16'h77), 1'b1);
    chk("empty_wr_rd_count", 32'(count), 1);
    chk("empty_wr_rd_head", 32'(item_out), 32'h77);

    // fill then 300 drops
    for (int i = 0; i < 3; i++) cyc(1'b1, flit_t'(16'h80 + i), 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, flit_t'($urandom), 1'b0);
    chk("sat_count", 32'(count), 4);
`ifdef CHANNEL_DROP_CNT_EN
    chk("drop_cnt_sat", 32'(drop_cnt), 255);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);

    // wrap-around stream at count 2
    cyc(1'b1, flit_t'(16'h0F0), 1'b0);
    cyc(1'b1, flit_t'(16'h0F1), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, flit_t'(16'h100 + i), 1'b1);
      chk("wrap_busy", 32'(busy), 0);
    end
    chk("wrap_count", 32'(count), 2);
    chk("wrap_head", 32'(item_out), 32'h112);

    // asynchronous reset mid-stream at count 3
    cyc(1'b1, flit_t'(16'h33), 1'b0);
    chk("pre_rst_count", 32'(count), 3);
    ena_in = 1'b0;
    reset  = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_item", 32'(item_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 6, flit_t'($urandom), $urandom_range(0, 1) == 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
